// File: rtl/sha3_pkg.sv
// ============================================================================
// sha3_pkg : shared widths for the SHA-3 output path (digest word, beat, FIFO entry)
// Rev 1.0
// ============================================================================
`default_nettype none

package sha3_pkg;

    localparam int DST_W       = 64;
    localparam int DST_OW      = 32;
    localparam int DST_ENTRY_W = DST_W + 1;

    // A FIFO entry carries the digest word plus its "last word" marker.
    function automatic int dst_entry_width(input int w);
        return w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha3_dst_fifo_mem.sv
// ============================================================================
// sha3_dst_fifo_mem : DEPTH x EW register array, one write port, async read port
// Rev 1.0
// ============================================================================
`default_nettype none

module sha3_dst_fifo_mem #(
    parameter int EW    = 65,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sha3_dst_fifo.sv
// ============================================================================
// sha3_dst_fifo : digest word FIFO, W-bit words out as two OW-bit beats MSB first.
// Optional macro SHA3_DST_OVERFLOW_FLAG_EN adds a sticky overflow output. Rev 1.0
// ============================================================================
`default_nettype none

module sha3_dst_fifo
    import sha3_pkg::*;
#(
    parameter int W     = DST_W,
    parameter int DEPTH = 8,
    parameter int OW    = DST_OW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             din,
    input  logic                     din_write,
    input  logic                     din_last,
    output logic                     dst_ready,
    output logic [OW-1:0]            dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic [$clog2(DEPTH):0]   level
`ifdef SHA3_DST_OVERFLOW_FLAG_EN
    ,
    output logic                     overflow
`endif
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              EW         = dst_entry_width(W);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          half;
    logic [EW-1:0] rd_entry;
    logic          full;
    logic          write_ok;
    logic          beat_take;
    logic          pop;

    // Full is judged on the pre-pop count, so a write racing a pop from full is lost.
    assign full      = (count == FULL_COUNT);
    assign write_ok  = din_write && !full;
    assign beat_take = dout_valid && dout_ready;
    assign pop       = beat_take && half;

    sha3_dst_fifo_mem #(
        .EW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (write_ok),
        .waddr (wr_ptr),
        .wdata ({din_last, din}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            half   <= 1'b0;
        end else begin
            if (write_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (beat_take) begin
                half <= ~half;
            end
            case ({write_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef SHA3_DST_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (din_write && full) begin
            overflow <= 1'b1;
        end
    end
`endif

    assign dst_ready  = full;
    assign dout_valid = (count != '0);
    assign dout       = half ? rd_entry[OW-1:0] : rd_entry[W-1:OW];
    assign dout_last  = rd_entry[W] && half && dout_valid;
    assign level      = count;

endmodule

`default_nettype wire

// File: tb/tb_sha3_dst_fifo.sv
// ============================================================================
// tb_sha3_dst_fifo : randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha3_dst_fifo;

    localparam int W     = 64;
    localparam int OW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic          din_write;
    logic          din_last;
    logic          dst_ready;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [LW-1:0] level;
`ifdef SHA3_DST_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: a queue of {last, word} plus which half of the head word is due.
    logic [W:0] q[$];
    bit         m_half;
    bit         m_ovf;

    always #5 clk = ~clk;

    sha3_dst_fifo #(.W(W), .DEPTH(DEPTH), .OW(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_write  (din_write),
        .din_last   (din_last),
        .dst_ready  (dst_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .level      (level)
`ifdef SHA3_DST_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W:0] head;
        check("dst_ready", dst_ready, q.size() == DEPTH);
        check("dout_valid", dout_valid, q.size() > 0);
        check("level", level, q.size());
        if (q.size() > 0) begin
            head = q[0];
            check("dout", dout, m_half ? head[OW-1:0] : head[W-1:OW]);
            check("dout_last", dout_last, head[W] && m_half);
        end else begin
            check("dout_last_idle", dout_last, 0);
        end
`ifdef SHA3_DST_OVERFLOW_FLAG_EN
        check("overflow", overflow, m_ovf);
`endif
    endtask

    // Called at a negedge: drive, check, clock, then advance the model.
    task automatic step(input bit wr, input logic [W-1:0] d, input bit lst,
                        input bit rdy, input bit rs);
        bit was_full;
        bit take;
        din = d; din_write = wr; din_last = lst; dout_ready = rdy; rst = rs;
        #1;
        check_outputs();
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        take = (q.size() > 0) && rdy;
        if (rs) begin
            q.delete();
            m_half = 0;
            m_ovf  = 0;
        end else begin
            if (take && m_half) void'(q.pop_front());
            if (take) m_half = !m_half;
            if (wr && !was_full) q.push_back({lst, d});
            if (wr && was_full) m_ovf = 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b1; din = '0; din_write = 0; din_last = 0; dout_ready = 0;
        m_half = 0; m_ovf = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", dout_valid, 0);
        check("rst_level", level, 0);
        check("rst_ready", dst_ready, 0);

        // Single word, two beats MSB first
        step(1, 64'h0123456789ABCDEF, 1, 1, 0);
        check("single_hi", dout, 32'h01234567);
        check("single_hi_last", dout_last, 0);
        step(0, '0, 0, 1, 0);
        check("single_lo", dout, 32'h89ABCDEF);
        check("single_lo_last", dout_last, 1);
        step(0, '0, 0, 1, 0);
        check("single_empty", dout_valid, 0);

        // Fill, drop a 9th, then full with simultaneous pop and write
        for (int i = 0; i < DEPTH; i++) step(1, rnd64(), i == DEPTH-1, 0, 0);
        check("fill_ready", dst_ready, 1);
        check("fill_level", level, DEPTH);
        step(1, rnd64(), 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(1, rnd64(), 1, 1, 0);
        check("full_pop_level", level, DEPTH-1);
        while (q.size() > 0) step(0, '0, 0, 1, 0);

        // Steady state: a write every other cycle, consumer always ready
        for (int i = 0; i < 40; i++) begin
            step(i % 2 == 0, rnd64(), i == 38, 1, 0);
            check("steady_level", level <= 1, 1);
        end
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, rnd64(), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, 0);
        end

        // Reset after the first beat of a word has gone out
        while (q.size() > 0) step(0, '0, 0, 1, 0);
        step(1, rnd64(), 1, 0, 0);
        step(1, rnd64(), 0, 1, 0);
        step(0, '0, 0, 0, 1);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_level", level, 0);
        step(1, 64'hFEDCBA9876543210, 0, 0, 0);
        check("restart_hi", dout, 32'hFEDCBA98);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
